alu_scheduler: RTL and testbench

Shares one 16-bit ALU between two requesters. Each request is an operand pair plus a 4-bit opcode. The block round-robin-arbitrates between the requesters, drives the ALU's enable, operand and opcode inputs for the ALU's pipeline latency, then captures the ALU's result and flags. It returns them to the requester that issued the operation over a valid/ready response handshake. It sits between the register-file/control logic and the ALU instance.

---
 rtl/alu_scheduler_if.sv | 39 +++
 rtl/alu_scheduler.sv | 158 +++++++++++++++
 tb/tb_alu_scheduler.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_scheduler_if.sv
// Requester, response and ALU-side signals of alu_scheduler, grouped as one bundle.
// The scheduler uses the slave modport; the environment that surrounds it uses master.
interface alu_scheduler_if;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [15:0] req0_a;
    logic [15:0] req0_b;
    logic [15:0] req1_a;
    logic [15:0] req1_b;
    logic [3:0]  req0_op;
    logic [3:0]  req1_op;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [15:0] rsp_result;
    logic [3:0]  rsp_flags;
    logic        alu_enable;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [3:0]  alu_op;
    logic [15:0] alu_result;
    logic        alu_zero;
    logic        alu_carry;
    logic        alu_overflow;
    logic        busy;

    modport slave (
        input  req_valid, req0_a, req0_b, req1_a, req1_b, req0_op, req1_op,
        input  rsp_ready, alu_result, alu_zero, alu_carry, alu_overflow,
        output req_ready, rsp_valid, rsp_result, rsp_flags,
        output alu_enable, alu_a, alu_b, alu_op, busy
    );

    modport master (
        output req_valid, req0_a, req0_b, req1_a, req1_b, req0_op, req1_op,
        output rsp_ready, alu_result, alu_zero, alu_carry, alu_overflow,
        input  req_ready, rsp_valid, rsp_result, rsp_flags,
        input  alu_enable, alu_a, alu_b, alu_op, busy
    );
endinterface

// File: rtl/alu_scheduler.sv
// Round-robin sharing of one pipelined 16-bit ALU between two requesters.
// Optional ALU_SCHED_OPCHECK_EN: opcodes above 4'b1011 bypass the ALU and return an error response.
module alu_scheduler #(
    parameter int ALU_LATENCY = 2
) (
    input  logic            clk,
    input  logic            reset,
    alu_scheduler_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, EXEC, CAPTURE, RESP} state_e;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  op;
    } req_t;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    req_t        op_q, op_d;
    logic        owner_q, owner_d;
    logic        last_grant_q, last_grant_d;
    logic        err_q, err_d;
    logic [15:0] res_q, res_d;
    logic [3:0]  flags_q, flags_d;

    logic        gnt;
    logic        accept;
    logic        illegal;
    req_t        sel;
    logic [1:0]  rdy;
    logic [1:0]  rvld;

    // Tie goes to whoever did not win last time; a lone requester always wins.
    always_comb begin
        gnt = 1'b0;
        case (bus.req_valid)
            2'b01:   gnt = 1'b0;
            2'b10:   gnt = 1'b1;
            2'b11:   gnt = ~last_grant_q;
            default: gnt = 1'b0;
        endcase
    end

    always_comb begin
        sel = '{a: bus.req0_a, b: bus.req0_b, op: bus.req0_op};
        if (gnt) begin
            sel = '{a: bus.req1_a, b: bus.req1_b, op: bus.req1_op};
        end
    end

`ifdef ALU_SCHED_OPCHECK_EN
    assign illegal = (sel.op > 4'b1011);
`else
    assign illegal = 1'b0;
`endif

    assign accept = (state_q == IDLE) && !reset && (|bus.req_valid);

    always_comb begin
        rdy  = 2'b00;
        rvld = 2'b00;
        for (int i = 0; i < 2; i++) begin
            rdy[i]  = accept && bus.req_valid[i] && (gnt == 1'(i));
            rvld[i] = (state_q == RESP) && (owner_q == 1'(i));
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        op_d         = op_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        err_d        = err_q;
        res_d        = res_q;
        flags_d      = flags_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    owner_d      = gnt;
                    last_grant_d = gnt;
                    err_d        = illegal;
                    cnt_d        = 4'(ALU_LATENCY);
                    // Rejected opcodes never reach the ALU, so its operand bus keeps its old value.
                    if (illegal) begin
                        state_d = CAPTURE;
                    end else begin
                        op_d    = sel;
                        state_d = EXEC;
                    end
                end
            end
            EXEC: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                if (err_q) begin
                    res_d   = 16'h0000;
                    flags_d = 4'b1000;
                end else begin
                    res_d   = bus.alu_result;
                    flags_d = {1'b0, bus.alu_overflow, bus.alu_carry, bus.alu_zero};
                end
                state_d = RESP;
            end
            RESP: begin
                if (bus.rsp_ready[owner_q]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q        <= 4'd0;
            op_q         <= '0;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            err_q        <= 1'b0;
            res_q        <= 16'h0000;
            flags_q      <= 4'b0000;
        end else begin
            cnt_q        <= cnt_d;
            op_q         <= op_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            err_q        <= err_d;
            res_q        <= res_d;
            flags_q      <= flags_d;
        end
    end

    assign bus.req_ready  = rdy;
    assign bus.rsp_valid  = rvld;
    assign bus.rsp_result = res_q;
    assign bus.rsp_flags  = flags_q;
    assign bus.alu_enable = (state_q == EXEC);
    assign bus.alu_a      = op_q.a;
    assign bus.alu_b      = op_q.b;
    assign bus.alu_op     = op_q.op;
    assign bus.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_scheduler.sv
// Bench for alu_scheduler: pipelined ALU model plus a transaction-level reference for
// arbitration, results and cycle timing, with directed and random transactions.
module tb_alu_scheduler;

    localparam int L = 2;
`ifdef ALU_SCHED_OPCHECK_EN
    localparam bit OPCHECK = 1'b1;
`else
    localparam bit OPCHECK = 1'b0;
`endif

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    alu_scheduler_if bus ();

    alu_scheduler #(.ALU_LATENCY(L)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU: returns {overflow, carry, zero, result}.
    function automatic logic [18:0] alu_f(input logic [15:0] a, input logic [15:0] b,
                                          input logic [3:0] op);
        logic [16:0] s;
        logic [15:0] r;
        logic        c;
        logic        v;
        c = 1'b0;
        v = 1'b0;
        s = 17'h0;
        case (op)
            4'd0: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[15:0];
                c = s[16];
                v = (a[15] == b[15]) && (r[15] != a[15]);
            end
            4'd1: begin
                r = a - b;
                c = (a < b);
                v = (a[15] != b[15]) && (r[15] != a[15]);
            end
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd5: begin
                r = {a[14:0], 1'b0};
                c = a[15];
            end
            default: r = ~(a ^ b);
        endcase
        return {v, c, (r == 16'h0000), r};
    endfunction

    // External ALU: result registered through L enabled stages.
    logic [18:0] pipe [L];
    always @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < L; k++) pipe[k] <= '0;
        end else if (bus.alu_enable) begin
            pipe[0] <= alu_f(bus.alu_a, bus.alu_b, bus.alu_op);
            for (int k = 1; k < L; k++) pipe[k] <= pipe[k-1];
        end
    end
    assign bus.alu_result   = pipe[L-1][15:0];
    assign bus.alu_zero     = pipe[L-1][16];
    assign bus.alu_carry    = pipe[L-1][17];
    assign bus.alu_overflow = pipe[L-1][18];

    // Transaction-level model state.
    logic        m_last;
    logic [35:0] m_alu;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble();
        bus.req_valid = 2'($urandom);
        bus.req0_a    = 16'($urandom);
        bus.req0_b    = 16'($urandom);
        bus.req0_op   = 4'($urandom);
        bus.req1_a    = 16'($urandom);
        bus.req1_b    = 16'($urandom);
        bus.req1_op   = 4'($urandom);
    endtask

    // Runs one request through to its response; caller leaves the block idle at entry.
    task automatic run_txn(input logic [1:0] vld,
                           input logic [15:0] a0, input logic [15:0] b0, input logic [3:0] op0,
                           input logic [15:0] a1, input logic [15:0] b1, input logic [3:0] op1,
                           input int bp);
        logic        w;
        logic [1:0]  oh;
        logic [15:0] ea, eb;
        logic [3:0]  eop;
        logic        ill;
        logic [18:0] f;
        logic [15:0] eres;
        logic [3:0]  eflags;
        int          nexec;

        w      = (vld == 2'b11) ? ~m_last : vld[1];
        m_last = w;
        oh     = w ? 2'b10 : 2'b01;
        ea     = w ? a1 : a0;
        eb     = w ? b1 : b0;
        eop    = w ? op1 : op0;
        ill    = OPCHECK && (eop > 4'b1011);
        f      = alu_f(ea, eb, eop);
        eres   = ill ? 16'h0000 : f[15:0];
        eflags = ill ? 4'b1000 : {1'b0, f[18], f[17], f[16]};
        if (!ill) m_alu = {ea, eb, eop};
        nexec  = ill ? 0 : L;

        bus.req_valid = vld;
        bus.req0_a = a0; bus.req0_b = b0; bus.req0_op = op0;
        bus.req1_a = a1; bus.req1_b = b1; bus.req1_op = op1;
        #1;
        chk("req_ready_grant", 32'(bus.req_ready), 32'(oh));
        chk("busy_idle", 32'(bus.busy), 32'd0);
        tick();

        for (int k = 0; k < nexec; k++) begin
            scramble();
            #1;
            chk("exec_enable", 32'(bus.alu_enable), 32'd1);
            chk("exec_operands", 32'({bus.alu_a, bus.alu_b}), 32'(m_alu[35:4]));
            chk("exec_op", 32'(bus.alu_op), 32'(m_alu[3:0]));
            chk("exec_rsp_valid", 32'(bus.rsp_valid), 32'd0);
            chk("exec_req_ready", 32'(bus.req_ready), 32'd0);
            tick();
        end

        scramble();
        #1;
        chk("capture_enable", 32'(bus.alu_enable), 32'd0);
        chk("capture_alu_a", 32'(bus.alu_a), 32'(m_alu[35:20]));
        chk("capture_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("capture_busy", 32'(bus.busy), 32'd1);
        tick();

        for (int j = 0; j <= bp; j++) begin
            scramble();
            bus.rsp_ready = (2'($urandom) & ~oh) | ((j == bp) ? oh : 2'b00);
            #1;
            chk("rsp_valid", 32'(bus.rsp_valid), 32'(oh));
            chk("rsp_result", 32'(bus.rsp_result), 32'(eres));
            chk("rsp_flags", 32'(bus.rsp_flags), 32'(eflags));
            chk("rsp_req_ready", 32'(bus.req_ready), 32'd0);
            chk("rsp_enable", 32'(bus.alu_enable), 32'd0);
            tick();
        end

        bus.rsp_ready = 2'b00;
        bus.req_valid = 2'b00;
        #1;
        chk("post_busy", 32'(bus.busy), 32'd0);
        chk("post_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        m_last = 1'b1;
        m_alu  = '0;
        reset  = 1'b1;
        bus.rsp_ready = 2'b00;
        scramble();
        bus.req_valid = 2'b01;
        tick(); tick(); tick();
        #1;
        chk("reset_req_ready", 32'(bus.req_ready), 32'd0);
        chk("reset_busy", 32'(bus.busy), 32'd0);
        chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("reset_result", 32'(bus.rsp_result), 32'd0);
        chk("reset_flags", 32'(bus.rsp_flags), 32'd0);
        chk("reset_alu", 32'({bus.alu_enable, bus.alu_a, bus.alu_op}), 32'd0);
        reset = 1'b0;
        bus.req_valid = 2'b00;
        tick();

        // Single ADD from requester 0, then SUB with borrow.
        run_txn(2'b01, 16'h0003, 16'h0004, 4'h0, 16'h1234, 16'h5678, 4'h2, 0);
        run_txn(2'b01, 16'h0001, 16'h0002, 4'h1, 16'h0000, 16'h0000, 4'h0, 1);

        // Ties alternate; first tie after the ADD/SUB pair goes to requester 1.
        for (int t = 0; t < 4; t++) begin
            run_txn(2'b11, 16'($urandom), 16'($urandom), 4'($urandom_range(0, 5)),
                    16'($urandom), 16'($urandom), 4'($urandom_range(0, 5)), 0);
        end

        // Long response backpressure, then an opcode outside the normal range.
        run_txn(2'b10, 16'h0000, 16'h0000, 4'h0, 16'h8000, 16'h8000, 4'h0, 10);
        run_txn(2'b10, 16'h0000, 16'h0000, 4'h0, 16'hA5A5, 16'h0F0F, 4'hF, 0);

        // Reset during EXEC discards the operation.
        bus.req_valid = 2'b01;
        bus.req0_a = 16'h1111; bus.req0_b = 16'h2222; bus.req0_op = 4'h0;
        tick();
        bus.req_valid = 2'b11;
        #1;
        chk("midexec_enable", 32'(bus.alu_enable), 32'd1);
        reset = 1'b1;
        #1;
        chk("midexec_req_ready", 32'(bus.req_ready), 32'd0);
        tick();
        reset = 1'b0;
        bus.req_valid = 2'b00;
        bus.rsp_ready = 2'b11;
        m_last = 1'b1;
        m_alu  = '0;
        #1;
        chk("after_reset_enable", 32'(bus.alu_enable), 32'd0);
        chk("after_reset_busy", 32'(bus.busy), 32'd0);
        chk("after_reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("after_reset_alu_a", 32'(bus.alu_a), 32'd0);
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("no_discarded_rsp", 32'(bus.rsp_valid), 32'd0);
        end
        bus.rsp_ready = 2'b00;

        // First tie after reset goes to requester 0.
        run_txn(2'b11, 16'h00FF, 16'hFF01, 4'h0, 16'h0001, 16'h0001, 4'h1, 0);
        run_txn(2'b11, 16'h7FFF, 16'h0001, 4'h0, 16'h0001, 16'h0001, 4'h1, 0);

        for (int n = 0; n < 30; n++) begin
            run_txn(2'($urandom_range(1, 3)),
                    16'($urandom), 16'($urandom), 4'($urandom),
                    16'($urandom), 16'($urandom), 4'($urandom),
                    int'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
